// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit ALU between NREQ requesters,
// with illegal-op screening, an issue timeout and a tagged valid/ready response.
module alu_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 4,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   req_fn,
    input  logic [8*NREQ-1:0]   req_op1,
    input  logic [8*NREQ-1:0]   req_op2,
    output logic [NREQ-1:0]     req_ack,
    output logic                alu_enable,
    output logic [2:0]          alu_fn,
    output logic [7:0]          alu_op1,
    output logic [7:0]          alu_op2,
    input  logic [15:0]         alu_result,
    input  logic                alu_valid,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [15:0]         rsp_data,
    output logic                rsp_err,
    output logic                busy,
    output logic [15:0]         issue_cnt
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT - 1);

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [3:0]     timer;

    logic           gnt_found;
    logic [IDW-1:0] gnt_id;
    logic [2:0]     sel_fn;
    logic [7:0]     sel_op1;
    logic [7:0]     sel_op2;
    logic           sel_illegal;

    // Scan downward so the requester closest to rr_ptr (lowest offset) is the last, winning assignment.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NREQ]) begin
                gnt_found = 1'b1;
                gnt_id    = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    assign sel_fn      = req_fn[3*int'(gnt_id) +: 3];
    assign sel_op1     = req_op1[8*int'(gnt_id) +: 8];
    assign sel_op2     = req_op2[8*int'(gnt_id) +: 8];
    assign sel_illegal = (sel_fn > 3'd5) || ((sel_fn == 3'd3) && (sel_op2 == 8'd0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            timer      <= '0;
            req_ack    <= '0;
            alu_enable <= 1'b0;
            alu_fn     <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            busy       <= 1'b0;
            issue_cnt  <= '0;
        end else begin
            req_ack    <= '0;
            alu_enable <= 1'b0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        req_ack <= {{(NREQ-1){1'b0}}, 1'b1} << gnt_id;
                        alu_fn  <= sel_fn;
                        alu_op1 <= sel_op1;
                        alu_op2 <= sel_op2;
                        rsp_id  <= gnt_id;
                        busy    <= 1'b1;
                        // Illegal ops are answered directly without touching the ALU.
                        if (sel_illegal) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_data  <= '0;
                            state     <= RESP;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    alu_enable <= 1'b1;
                    issue_cnt  <= issue_cnt + 16'd1;
                    timer      <= '0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (alu_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b0;
                        rsp_data  <= alu_result;
                        state     <= RESP;
                    end else if (timer == TIMER_LAST) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_data  <= '0;
                        state     <= RESP;
                    end else begin
                        timer <= timer + 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        rr_ptr    <= (rsp_id == IDW'(NREQ - 1)) ? '0 : rsp_id + IDW'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: directed scenarios plus randomized rounds checked
// against a round-robin reference model and a behavioural ALU.
module tb_alu_arbiter;

    localparam int NREQ    = 4;
    localparam int TIMEOUT = 4;
    localparam int IDW     = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req = '0;
    logic [3*NREQ-1:0]   req_fn = '0;
    logic [8*NREQ-1:0]   req_op1 = '0;
    logic [8*NREQ-1:0]   req_op2 = '0;
    logic [NREQ-1:0]     req_ack;
    logic                alu_enable;
    logic [2:0]          alu_fn;
    logic [7:0]          alu_op1;
    logic [7:0]          alu_op2;
    logic [15:0]         alu_result;
    logic                alu_valid;
    logic                rsp_valid;
    logic                rsp_ready = 1'b1;
    logic [IDW-1:0]      rsp_id;
    logic [15:0]         rsp_data;
    logic                rsp_err;
    logic                busy;
    logic [15:0]         issue_cnt;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [15:0]    data;
        logic           err;
    } rsp_t;

    rsp_t exp_q[$];
    int   ack_q[$];
    int   compared = 0;
    int   mismatched = 0;
    int   cyc = 0;
    int   en_count = 0;
    int   ack_seen = 0;
    int   model_ptr = 0;
    int   model_issues = 0;
    logic alu_stuck = 1'b0;
    bit   auto_drop = 1'b1;
    bit   rand_ready = 1'b0;
    logic [2:0] round_fn[NREQ];
    logic [7:0] round_op1[NREQ];
    logic [7:0] round_op2[NREQ];

    alu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .req_fn(req_fn), .req_op1(req_op1),
        .req_op2(req_op2), .req_ack(req_ack), .alu_enable(alu_enable), .alu_fn(alu_fn),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_result(alu_result),
        .alu_valid(alu_valid), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
        .issue_cnt(issue_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] alu_func(logic [2:0] fn, logic [7:0] a, logic [7:0] b);
        case (fn)
            3'd0:    return 16'(a) + 16'(b);
            3'd1:    return 16'(a) - 16'(b);
            3'd2:    return 16'(a) * 16'(b);
            3'd3:    return (b == 8'd0) ? 16'd0 : 16'(a / b);
            3'd4:    return {8'h00, a & b};
            3'd5:    return {8'h00, a | b};
            default: return 16'd0;
        endcase
    endfunction

    // Behavioural registered ALU; alu_stuck suppresses its valid to force timeouts.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_valid  <= 1'b0;
            alu_result <= '0;
        end else begin
            alu_valid <= alu_enable && !alu_stuck;
            if (alu_enable) alu_result <= alu_func(alu_fn, alu_op1, alu_op2);
        end
    end

    task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, required);
        end
    endtask

    task automatic reportFail(string name, logic [31:0] actual);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: actual=0x%0h required=none", name, actual);
    endtask

    // Monitor: pops the scoreboard on every response handshake and every ack pulse.
    initial begin
        rsp_t       e;
        int         exp_id;
        bit         hold_valid;
        logic [18:0] held;
        hold_valid = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                ack_q.delete();
                hold_valid = 1'b0;
                en_count = 0;
            end else begin
                if (alu_enable) en_count++;
                if (req_ack != '0) begin
                    if (ack_q.size() == 0) reportFail("unexpected_ack", 32'(req_ack));
                    else begin
                        exp_id = ack_q.pop_front();
                        checkOutput("req_ack", 32'(req_ack), 32'(1) << exp_id);
                    end
                end
                if (hold_valid)
                    checkOutput("rsp_hold", {12'd0, rsp_valid, rsp_err, rsp_id, rsp_data},
                                {12'd0, 1'b1, held});
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) reportFail("unexpected_rsp", 32'({rsp_id, rsp_data, rsp_err}));
                    else begin
                        e = exp_q.pop_front();
                        checkOutput("rsp", 32'({rsp_id, rsp_data, rsp_err}), 32'(e));
                    end
                end
                hold_valid = rsp_valid && !rsp_ready;
                held = {rsp_err, rsp_id, rsp_data};
            end
        end
    end

    task automatic stepCycle();
        @(posedge clk);
        #1;
        if (req_ack != '0) ack_seen++;
        if (auto_drop) req = req & ~req_ack;
        if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic applyReset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("reset_ctrl", 32'({req_ack, alu_enable, rsp_valid, rsp_err, busy, rsp_id, alu_fn}), 32'd0);
        checkOutput("reset_data", {alu_op1, alu_op2, rsp_data}, 32'd0);
        checkOutput("reset_issue_cnt", 32'(issue_cnt), 32'd0);
        req = '0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_ptr = 0;
        model_issues = 0;
    endtask

    task automatic applyStimulus(int idx, logic [2:0] fn, logic [7:0] op1, logic [7:0] op2);
        req_fn[3*idx +: 3]  = fn;
        req_op1[8*idx +: 8] = op1;
        req_op2[8*idx +: 8] = op2;
        req[idx] = 1'b1;
    endtask

    function automatic int pickNext(logic [NREQ-1:0] pending);
        for (int k = 0; k < NREQ; k++)
            if (pending[(model_ptr + k) % NREQ]) return (model_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic pushExpect(int id, logic [2:0] fn, logic [7:0] op1, logic [7:0] op2);
        rsp_t e;
        bit   legal;
        legal = (fn <= 3'd5) && !(fn == 3'd3 && op2 == 8'd0);
        e.id   = IDW'(id);
        e.data = legal ? alu_func(fn, op1, op2) : 16'd0;
        e.err  = !legal;
        ack_q.push_back(id);
        exp_q.push_back(e);
        if (legal) model_issues++;
        model_ptr = (id + 1) % NREQ;
    endtask

    // Predicts the service order of a set of requests that are each dropped on their ack.
    task automatic issueRound(logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pending;
        int id;
        pending = mask;
        while (pending != '0) begin
            id = pickNext(pending);
            pushExpect(id, round_fn[id], round_op1[id], round_op2[id]);
            pending[id] = 1'b0;
        end
        for (int i = 0; i < NREQ; i++)
            if (mask[i]) applyStimulus(i, round_fn[i], round_op1[i], round_op2[i]);
    endtask

    task automatic waitDrain(int budget, string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ack_q.size() != 0 || busy || req != '0) && n < budget) begin
            stepCycle();
            n++;
        end
        if (exp_q.size() != 0 || ack_q.size() != 0 || busy || req != '0)
            reportFail(name, 32'(exp_q.size()));
    endtask

    task automatic waitSignal(bit use_valid, int budget, string name);
        int n;
        n = 0;
        while (!(use_valid ? rsp_valid : alu_enable) && n < budget) begin
            stepCycle();
            n++;
        end
        if (!(use_valid ? rsp_valid : alu_enable)) reportFail(name, 32'(n));
    endtask

    initial begin
        int c;
        int w;
        logic [NREQ-1:0] mask;

        applyReset();

        // Single legal add: latency, one issue, operand registers hold afterwards.
        c = cyc;
        round_fn[0] = 3'd0; round_op1[0] = 8'd200; round_op2[0] = 8'd100;
        issueRound(4'b0001);
        waitSignal(1'b1, 20, "t1_rsp_timeout");
        checkOutput("t1_latency", 32'(cyc - c), 32'd4);
        waitDrain(50, "t1_drain");
        checkOutput("t1_en_count", 32'(en_count), 32'd1);
        checkOutput("t1_issue_cnt", 32'(issue_cnt), 32'd1);
        checkOutput("t1_alu_regs", {13'd0, alu_fn, alu_op1, alu_op2}, {13'd0, 3'd0, 8'd200, 8'd100});

        // All four held: fairness order 0,1,2,3,0.
        applyReset();
        auto_drop = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            round_fn[i] = 3'd2; round_op1[i] = 8'(i + 1); round_op2[i] = 8'd3;
        end
        for (int n = 0; n < 5; n++) begin
            w = pickNext(4'hF);
            pushExpect(w, round_fn[w], round_op1[w], round_op2[w]);
        end
        for (int i = 0; i < NREQ; i++) applyStimulus(i, round_fn[i], round_op1[i], round_op2[i]);
        ack_seen = 0;
        for (int n = 0; n < 200 && ack_seen < 5; n++) stepCycle();
        if (ack_seen < 5) reportFail("t2_ack_timeout", 32'(ack_seen));
        req = '0;
        auto_drop = 1'b1;
        waitDrain(100, "t2_drain");
        checkOutput("t2_issue_cnt", 32'(issue_cnt), 32'(model_issues));

        // Illegal ops: divide by zero and fn 6.
        round_fn[2] = 3'd3; round_op1[2] = 8'd50; round_op2[2] = 8'd0;
        issueRound(4'b0100);
        waitDrain(50, "t3a_drain");
        round_fn[2] = 3'd6; round_op1[2] = 8'd7; round_op2[2] = 8'd9;
        issueRound(4'b0100);
        waitDrain(50, "t3b_drain");
        checkOutput("t3_issue_cnt", 32'(issue_cnt), 32'(model_issues));
        checkOutput("t3_en_count", 32'(en_count), 32'(model_issues));

        // Back-pressure: response held while another request waits.
        rsp_ready = 1'b0;
        round_fn[0] = 3'd0; round_op1[0] = 8'd10; round_op2[0] = 8'd20;
        round_fn[1] = 3'd1; round_op1[1] = 8'd50; round_op2[1] = 8'd8;
        issueRound(4'b0011);
        waitSignal(1'b1, 20, "t4_rsp_timeout");
        ack_seen = 0;
        repeat (5) stepCycle();
        checkOutput("t4_no_ack_held", 32'(ack_seen), 32'd0);
        checkOutput("t4_valid_held", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        waitDrain(50, "t4_drain");

        // ALU never answers: timeout response exactly TIMEOUT cycles after WAIT entry.
        alu_stuck = 1'b1;
        begin
            rsp_t e;
            e.id = IDW'(3); e.data = 16'd0; e.err = 1'b1;
            ack_q.push_back(3);
            exp_q.push_back(e);
            model_issues++;
            model_ptr = 0;
        end
        applyStimulus(3, 3'd0, 8'd1, 8'd2);
        waitSignal(1'b0, 20, "t5_enable_timeout");
        w = cyc;
        waitSignal(1'b1, 20, "t5_rsp_timeout");
        checkOutput("t5_timeout_latency", 32'(cyc - w), 32'(TIMEOUT));
        waitDrain(50, "t5_drain");
        checkOutput("t5_issue_cnt", 32'(issue_cnt), 32'(model_issues));

        // Reset in the middle of WAIT, then normal service from a clean count.
        ack_q.push_back(0);
        applyStimulus(0, 3'd0, 8'd5, 8'd6);
        waitSignal(1'b0, 20, "t6_enable_timeout");
        stepCycle();
        alu_stuck = 1'b0;
        applyReset();
        round_fn[0] = 3'd2; round_op1[0] = 8'd7; round_op2[0] = 8'd6;
        issueRound(4'b0001);
        waitDrain(50, "t6_drain");
        checkOutput("t6_issue_cnt", 32'(issue_cnt), 32'd1);

        // Randomized rounds with random back-pressure.
        rand_ready = 1'b1;
        for (int r = 0; r < 30; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < NREQ; i++) begin
                round_fn[i]  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 5));
                round_op1[i] = 8'($urandom);
                round_op2[i] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            end
            issueRound(mask);
            waitDrain(400, "rand_drain");
        end
        rand_ready = 1'b0;
        rsp_ready = 1'b1;
        checkOutput("rand_issue_cnt", 32'(issue_cnt), 32'(model_issues));
        checkOutput("rand_en_count", 32'(en_count), 32'(model_issues));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
